// File: rtl/inst_fetch_pkg.sv
// Shared constants, PC-select encoding and address helpers for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;
    localparam int unsigned       PC_INC           = 4;
    localparam logic [WORD_W-1:0] NOP_INSTR        = '0;

    typedef enum logic [1:0] {
        PC_SEL_INC,
        PC_SEL_HOLD,
        PC_SEL_BRANCH
    } pc_sel_e;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
        return (a & ADDR_W'(3)) != '0;
    endfunction

endpackage

// File: rtl/inst_fetch_pc_register.sv
// Program counter with next-PC selection: redirect beats stall beats sequential advance.
module pc_register
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned       STEP     = PC_INC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus_inc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_plus_inc;
    pc_sel_e           w_sel;

    // Wraps modulo 2^32 by construction; no overflow indication.
    assign w_pc_plus_inc = r_pc + ADDR_W'(STEP);

    always_comb begin
        w_sel = PC_SEL_INC;
        if (i_branch_taken) begin
            w_sel = PC_SEL_BRANCH;
        end else if (i_stall) begin
            w_sel = PC_SEL_HOLD;
        end
    end

    always_comb begin
        w_pc_next = w_pc_plus_inc;
        case (w_sel)
            PC_SEL_BRANCH: w_pc_next = align_word(i_branch_target);
            PC_SEL_HOLD:   w_pc_next = r_pc;
            default:       w_pc_next = w_pc_plus_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_plus_inc = w_pc_plus_inc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and sticky misaligned-target flag.
module inst_fetch #(
    parameter logic [inst_fetch_pkg::ADDR_W-1:0] RESET_PC = inst_fetch_pkg::DEFAULT_RESET_PC,
    parameter int unsigned                       PC_INC   = inst_fetch_pkg::PC_INC
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              flush,
    input  logic                              branch_taken,
    input  logic [inst_fetch_pkg::ADDR_W-1:0] branch_target,
    output logic [inst_fetch_pkg::ADDR_W-1:0] imem_address,
    input  logic [inst_fetch_pkg::WORD_W-1:0] imem_read_data,
    output logic [inst_fetch_pkg::WORD_W-1:0] if_id_instr,
    output logic [inst_fetch_pkg::ADDR_W-1:0] if_id_pc_plus4,
    output logic                              if_id_valid,
    output logic                              misaligned
);

    import inst_fetch_pkg::*;

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_plus_inc;
    logic [WORD_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc_plus4;
    logic              r_valid;
    logic              r_misaligned;

    pc_register #(
        .RESET_PC (RESET_PC),
        .STEP     (PC_INC)
    ) u_pc_register (
        .clk             (clk),
        .reset           (reset),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_pc            (w_pc),
        .o_pc_plus_inc   (w_pc_plus_inc)
    );

    // A redirect squashes the slot even under stall; flush does so regardless of PC priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (branch_taken || flush) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (!stall) begin
            r_instr    <= imem_read_data;
            r_pc_plus4 <= w_pc_plus_inc;
            r_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misaligned <= 1'b0;
        end else if (branch_taken && is_misaligned(branch_target)) begin
            r_misaligned <= 1'b1;
        end
    end

    assign imem_address   = w_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc_plus4 = r_pc_plus4;
    assign if_id_valid    = r_valid;
    assign misaligned     = r_misaligned;

endmodule
